adc_range_ctrl: RTL and testbench
=================================

// Module: adc_range_ctrl
// PURPOSE
//  Auto-ranging controller for the LTC2313-14 beam-current front end. Watches converted samples,
//  decides when the gain range (A0/A1) must step up or down, and applies the change only while
//  the ADC is not acquiring a beam cycle. Holds off (busy) for an analog settle time after each
//  change. Sits beside ADC_LTC2313_14/SPI; o_range replaces the AXI-driven range bits.
// PARAMETERS
//  DATA_WIDTH    14     sample width
//  HI_THRESH     15000  sample >= this counts as over-scale
//  LO_THRESH     1200   sample <= this counts as under-scale
//  HYST_CNT      16     consecutive qualifying samples needed before a step request
//  SETTLE_CYCLES 2000   clocks o_range_busy stays high after a change (10 us at 200 MHz)
// PORTS
//  i_clk            in   1   system clock (200 MHz)
//  i_fRST           in   1   async reset, active-low
//  i_sample_valid   in   1   1-clk pulse, i_sample valid
//  i_sample         in   DATA_WIDTH  unsigned ADC code
//  i_adc_state      in   1   1 = beam-cycle acquisition in progress
//  i_auto_en        in   1   1 = automatic ranging enabled
//  i_range_wr       in   1   1-clk pulse, manual range write
//  i_manual_range   in   2   manual range code
//  i_flag_clr       in   1   1-clk pulse, clears o_over_range
//  o_range          out  2   {A1,A0}: 01=220uA, 10=2.2mA, 11=22mA; 00 never driven
//  o_range_busy     out  1   range settling; samples invalid
//  o_range_changed  out  1   1-clk pulse on every o_range update
//  o_over_range     out  1   sticky: over-scale run seen while already at 11
// BEHAVIOUR
//  Reset: o_range=11 (least sensitive), busy=0, changed=0, over_range=0, counters 0, FSM MONITOR.
//  Ordering: 01 < 10 < 11; "up" = toward 11, "down" = toward 01.
//  Counters (auto_en=1, state MONITOR only): valid sample >= HI -> hi_cnt++, lo_cnt=0;
//   <= LO -> lo_cnt++, hi_cnt=0; otherwise both 0. Saturate at HYST_CNT. Held 0 in other states.
//  FSM: MONITOR -> PENDING when hi_cnt reaches HYST_CNT and range!=11 (target=up), or lo_cnt
//   reaches HYST_CNT and range!=01 (target=down). hi run at range 11: set o_over_range, clear
//   hi_cnt, stay MONITOR. lo run at 01: clear lo_cnt, stay MONITOR.
//  PENDING -> SWITCH in the first cycle i_adc_state=0 (never mid beam cycle).
//  SWITCH (1 clk): o_range<=target, o_range_changed=1, busy=1 -> SETTLE.
//  SETTLE: count SETTLE_CYCLES clocks, busy=1; then busy=0, counters 0 -> MONITOR.
//  Latency: PENDING with adc idle -> o_range updated 1 clk later; busy high exactly
//   SETTLE_CYCLES+1 clocks from that edge.
//  Manual write: i_range_wr with code 00 ignored. Valid code in any state overrides any pending
//   auto target: -> PENDING with target=code (SWITCH when adc idle). In SETTLE the settle
//   counter restarts after the new SWITCH. Code equal to current o_range and no pending target:
//   ignored, no pulse. Accepted regardless of i_auto_en.
//  i_auto_en=0: counters cleared, no auto requests; a pending auto target is dropped (-> MONITOR).
//  i_flag_clr and new over-range set in same cycle: set wins.
//  Reset mid-SETTLE/PENDING: returns to reset state immediately, o_range=11.
// CONFIGURATION
//  ADC_RANGE_STATS_EN defined: adds o_up_cnt[15:0], o_down_cnt[15:0] outputs; count applied
//   up/down steps (auto and manual), saturate at 16'hFFFF, cleared by i_flag_clr and reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (bench params HYST_CNT=4, SETTLE_CYCLES=10, HI=15000, LO=1200)
//  Reset -> o_range=11, busy=0, changed=0, over_range=0.
//  auto_en=1, range 11, 4 samples of 500, adc_state=0 -> o_range=10 next clk after PENDING,
//   changed 1 clk, busy 11 clks; 4 more of 500 after settle -> o_range=01.
//  Range 01, adc_state=1, 4 samples of 16000 -> stays 01 until adc_state falls, then 10 next clk.
//  Range 11, 4 samples of 16383 -> over_range=1, o_range stays 11; i_flag_clr -> over_range=0.
//  Samples 16000,16000,16000,8000,16000 -> no change (run broken); range_wr code 00 -> ignored.
//  Pending auto down + range_wr 11 same cycle, adc idle -> o_range=11 (manual wins), one pulse.

Source files
------------

// File: rtl/adc_range_ctrl.sv
// Auto-ranging gain controller for the LTC2313-14 beam-current front end; range steps apply 1 clk after
// PENDING with the ADC idle, then busy holds for SETTLE_CYCLES+1 clocks. ADC_RANGE_STATS_EN adds step counters.
module adc_range_ctrl #(
  parameter int DATA_WIDTH    = 14,
  parameter int HI_THRESH     = 15000,
  parameter int LO_THRESH     = 1200,
  parameter int HYST_CNT      = 16,
  parameter int SETTLE_CYCLES = 2000
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_adc_state,
  input  logic                  i_auto_en,
  input  logic                  i_range_wr,
  input  logic [1:0]            i_manual_range,
  input  logic                  i_flag_clr,
`ifdef ADC_RANGE_STATS_EN
  output logic [15:0]           o_up_cnt,
  output logic [15:0]           o_down_cnt,
`endif
  output logic [1:0]            o_range,
  output logic                  o_range_busy,
  output logic                  o_range_changed,
  output logic                  o_over_range
);

  localparam int HCW = $clog2(HYST_CNT + 1);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DATA_WIDTH-1:0] HI_L        = DATA_WIDTH'(HI_THRESH);
  localparam logic [DATA_WIDTH-1:0] LO_L        = DATA_WIDTH'(LO_THRESH);
  localparam logic [HCW-1:0]        HYST_MAX    = HCW'(HYST_CNT);
  localparam logic [HCW-1:0]        HYST_LAST   = HCW'(HYST_CNT - 1);
  localparam logic [SCW-1:0]        SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]            RANGE_MIN   = 2'b01;
  localparam logic [1:0]            RANGE_MAX   = 2'b11;

  typedef enum logic [1:0] {MONITOR, PENDING, SWITCH, SETTLE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       range_q, range_d;
  logic [1:0]       target_q, target_d;
  logic             tgt_man_q, tgt_man_d;
  logic [HCW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [HCW-1:0]   lo_cnt_q, lo_cnt_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic             over_q, over_d;

  logic sample_hi, sample_lo, hi_run, lo_run, man_ok;

  assign sample_hi = i_sample_valid && (i_sample >= HI_L);
  assign sample_lo = i_sample_valid && (i_sample <= LO_L);
  // A run completes on the sample that would bring the count to HYST_CNT.
  assign hi_run = i_auto_en && (state_q == MONITOR) && sample_hi && (hi_cnt_q == HYST_LAST);
  assign lo_run = i_auto_en && (state_q == MONITOR) && sample_lo && (lo_cnt_q == HYST_LAST);
  assign man_ok = i_range_wr && (i_manual_range != 2'b00) &&
                  ((i_manual_range != range_q) || (state_q == PENDING));

  always_ff @(posedge i_clk or negedge i_fRST) begin
    if (!i_fRST) begin
      state_q   <= MONITOR;
      range_q   <= RANGE_MAX;
      target_q  <= RANGE_MAX;
      tgt_man_q <= 1'b0;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      settle_q  <= '0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      range_q   <= range_d;
      target_q  <= target_d;
      tgt_man_q <= tgt_man_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      settle_q  <= settle_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    range_d   = range_q;
    target_d  = target_q;
    tgt_man_d = tgt_man_q;
    settle_d  = settle_q;
    hi_cnt_d  = '0;
    lo_cnt_d  = '0;
    over_d    = over_q;

    if (hi_run && (range_q == RANGE_MAX)) begin
      over_d = 1'b1;
    end else if (i_flag_clr) begin
      over_d = 1'b0;
    end

    case (state_q)
      MONITOR: begin
        if (i_auto_en) begin
          if (sample_hi) begin
            hi_cnt_d = (hi_cnt_q == HYST_MAX) ? hi_cnt_q : hi_cnt_q + HCW'(1);
          end else if (sample_lo) begin
            lo_cnt_d = (lo_cnt_q == HYST_MAX) ? lo_cnt_q : lo_cnt_q + HCW'(1);
          end else if (!i_sample_valid) begin
            hi_cnt_d = hi_cnt_q;
            lo_cnt_d = lo_cnt_q;
          end
          if (hi_run) begin
            hi_cnt_d = '0;
            if (range_q != RANGE_MAX) begin
              state_d   = PENDING;
              target_d  = range_q + 2'd1;
              tgt_man_d = 1'b0;
            end
          end
          if (lo_run) begin
            lo_cnt_d = '0;
            if (range_q != RANGE_MIN) begin
              state_d   = PENDING;
              target_d  = range_q - 2'd1;
              tgt_man_d = 1'b0;
            end
          end
        end
      end
      PENDING: begin
        if (!i_auto_en && !tgt_man_q) begin
          state_d = MONITOR;
        end else if (!i_adc_state) begin
          state_d = SWITCH;
          range_d = target_q;
        end
      end
      SWITCH: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = MONITOR;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      default: state_d = MONITOR;
    endcase

    // A manual write supersedes whatever is in flight, including a same-cycle switch.
    if (man_ok) begin
      state_d   = PENDING;
      range_d   = range_q;
      target_d  = i_manual_range;
      tgt_man_d = 1'b1;
      hi_cnt_d  = '0;
      lo_cnt_d  = '0;
    end
  end

  always_comb begin
    o_range_changed = 1'b0;
    o_range_busy    = 1'b0;
    case (state_q)
      SWITCH: begin
        o_range_changed = 1'b1;
        o_range_busy    = 1'b1;
      end
      SETTLE:  o_range_busy = 1'b1;
      default: o_range_busy = 1'b0;
    endcase
  end

  assign o_range      = range_q;
  assign o_over_range = over_q;

`ifdef ADC_RANGE_STATS_EN
  logic [15:0] up_cnt_q, down_cnt_q;
  logic        applied;

  assign applied = (state_q == PENDING) && (state_d == SWITCH);

  always_ff @(posedge i_clk or negedge i_fRST) begin
    if (!i_fRST) begin
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
    end else if (i_flag_clr) begin
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
    end else if (applied) begin
      if ((target_q > range_q) && (up_cnt_q != 16'hFFFF)) up_cnt_q <= up_cnt_q + 16'd1;
      if ((target_q < range_q) && (down_cnt_q != 16'hFFFF)) down_cnt_q <= down_cnt_q + 16'd1;
    end
  end

  assign o_up_cnt   = up_cnt_q;
  assign o_down_cnt = down_cnt_q;
`endif

endmodule

// File: tb/tb_adc_range_ctrl.sv
// Randomized scoreboard bench for adc_range_ctrl: a sample-run model predicts each range step,
// a negedge monitor checks every o_range_changed pulse and every busy window.
module tb_adc_range_ctrl;
  localparam int HYST   = 4;
  localparam int SETTLE = 10;
  localparam int HI     = 15000;
  localparam int LO     = 1200;

  logic        i_clk = 1'b0;
  logic        i_fRST = 1'b1;
  logic        i_sample_valid = 1'b0;
  logic [13:0] i_sample = '0;
  logic        i_adc_state = 1'b0;
  logic        i_auto_en = 1'b1;
  logic        i_range_wr = 1'b0;
  logic [1:0]  i_manual_range = 2'b00;
  logic        i_flag_clr = 1'b0;
  logic [1:0]  o_range;
  logic        o_range_busy, o_range_changed, o_over_range;
`ifdef ADC_RANGE_STATS_EN
  logic [15:0] o_up_cnt, o_down_cnt;
`endif

  adc_range_ctrl #(
    .DATA_WIDTH(14), .HI_THRESH(HI), .LO_THRESH(LO), .HYST_CNT(HYST), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .i_clk(i_clk), .i_fRST(i_fRST), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .i_adc_state(i_adc_state), .i_auto_en(i_auto_en), .i_range_wr(i_range_wr),
    .i_manual_range(i_manual_range), .i_flag_clr(i_flag_clr),
`ifdef ADC_RANGE_STATS_EN
    .o_up_cnt(o_up_cnt), .o_down_cnt(o_down_cnt),
`endif
    .o_range(o_range), .o_range_busy(o_range_busy), .o_range_changed(o_range_changed),
    .o_over_range(o_over_range)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  // Reference model state: current range, qualifying run lengths, sticky flag.
  logic [1:0] mdl_range = 2'b11;
  int  hi_run = 0;
  int  lo_run = 0;
  bit  mdl_over = 1'b0;
  bit  mdl_auto = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every change pulse must match the next predicted range; every busy window is SETTLE+1 clocks.
  int busy_len = 0;
  always @(negedge i_clk) begin
    if (!i_fRST) begin
      busy_len = 0;
    end else begin
      if (o_range_changed) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change: got range %0d with nothing predicted at %0t", o_range, $time);
        end else begin
          chk("range_value", int'(o_range), int'(exp_q.pop_front()));
        end
      end
      if (o_range_busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        chk("busy_len", busy_len, SETTLE + 1);
        busy_len = 0;
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (o_range_busy && n < 200) begin
      tick;
      n++;
    end
    chk("settle_timeout", int'(o_range_busy), 0);
  endtask

  // DUT is PENDING: hold the ADC busy for h clocks, then the switch must land exactly one clock after idle.
  task automatic finish_step(input int h);
    i_adc_state = (h > 0);
    for (int k = 0; k < h; k++) begin
      tick;
      chk("hold_no_change", int'(o_range_changed), 0);
    end
    i_adc_state = 1'b0;
    tick;
    chk("switch_latency", int'(o_range_changed), 1);
    chk("range_after_switch", int'(o_range), int'(mdl_range));
    wait_idle();
  endtask

  task automatic send_sample(input logic [13:0] v, input int h, input bit fin);
    bit step = 1'b0;
    logic [1:0] nxt = mdl_range;
    i_sample = v;
    i_sample_valid = 1'b1;
    tick;
    i_sample_valid = 1'b0;
    if (mdl_auto) begin
      if (int'(v) >= HI) begin
        lo_run = 0;
        hi_run++;
        if (hi_run == HYST) begin
          hi_run = 0;
          if (mdl_range == 2'b11) mdl_over = 1'b1;
          else begin step = 1'b1; nxt = mdl_range + 2'd1; end
        end
      end else if (int'(v) <= LO) begin
        hi_run = 0;
        lo_run++;
        if (lo_run == HYST) begin
          lo_run = 0;
          if (mdl_range != 2'b01) begin step = 1'b1; nxt = mdl_range - 2'd1; end
        end
      end else begin
        hi_run = 0;
        lo_run = 0;
      end
    end
    if (step) begin
      exp_q.push_back(nxt);
      mdl_range = nxt;
      hi_run = 0;
      lo_run = 0;
      if (fin) finish_step(h);
    end
  endtask

  task automatic manual_wr(input logic [1:0] code, input int h);
    i_manual_range = code;
    i_range_wr = 1'b1;
    tick;
    i_range_wr = 1'b0;
    if (code != 2'b00 && code != mdl_range) begin
      exp_q.push_back(code);
      mdl_range = code;
      hi_run = 0;
      lo_run = 0;
      finish_step(h);
    end else begin
      repeat (3) tick;
      chk("manual_ignored_range", int'(o_range), int'(mdl_range));
    end
  endtask

  task automatic flag_clear;
    i_flag_clr = 1'b1;
    tick;
    i_flag_clr = 1'b0;
    mdl_over = 1'b0;
    chk("flag_clr", int'(o_over_range), 0);
  endtask

  task automatic set_auto(input bit b);
    if (b != mdl_auto) begin
      i_auto_en = b;
      tick;
      mdl_auto = b;
      hi_run = 0;
      lo_run = 0;
    end
  endtask

  function automatic logic [13:0] rand_val(input int c);
    int b = $urandom_range(0, 3);
    case (c)
      0:       return (b == 0) ? 14'd15000 : 14'($urandom_range(HI, 16383));
      1:       return (b == 0) ? 14'd1200 : 14'($urandom_range(0, LO));
      default: return (b == 0) ? 14'd1201 : (b == 1) ? 14'd14999 : 14'($urandom_range(LO + 1, HI - 1));
    endcase
  endfunction

  initial begin
    #2 i_fRST = 1'b0;
    tick;
    tick;
    chk("rst_range", int'(o_range), 3);
    chk("rst_busy", int'(o_range_busy), 0);
    chk("rst_changed", int'(o_range_changed), 0);
    chk("rst_over", int'(o_over_range), 0);
    i_fRST = 1'b1;
    tick;
    chk("post_rst_range", int'(o_range), 3);

    // Two down-steps from the least sensitive range; the second with the ADC busy briefly.
    repeat (4) send_sample(14'd500, 0, 1'b1);
    repeat (4) send_sample(14'd500, 2, 1'b1);
    chk("at_min_range", int'(o_range), 1);
    // Over-scale run while a beam cycle is in progress waits for the ADC to go idle.
    repeat (4) send_sample(14'd16000, 5, 1'b1);
    repeat (4) send_sample(14'd16000, 0, 1'b1);
    // Over-scale at the top range raises the sticky flag instead of stepping.
    repeat (4) send_sample(14'd16383, 0, 1'b1);
    chk("over_set", int'(o_over_range), int'(mdl_over));
    chk("over_range_hold", int'(o_range), 3);
    flag_clear();
    // A mid-scale sample breaks the run.
    send_sample(14'd16000, 0, 1'b1);
    send_sample(14'd16000, 0, 1'b1);
    send_sample(14'd16000, 0, 1'b1);
    send_sample(14'd8000, 0, 1'b1);
    send_sample(14'd16000, 0, 1'b1);
    repeat (3) tick;
    chk("broken_run_range", int'(o_range), 3);
    chk("broken_run_over", int'(o_over_range), 0);
    manual_wr(2'b00, 0);
    manual_wr(2'b11, 0);

    // Auto down-step pending, manual write of 11 in the same cycle: the manual code wins, one pulse.
    repeat (3) send_sample(14'd300, 0, 1'b1);
    send_sample(14'd300, 0, 1'b0);
    void'(exp_q.pop_back());
    mdl_range = 2'b11;
    exp_q.push_back(2'b11);
    i_manual_range = 2'b11;
    i_range_wr = 1'b1;
    i_adc_state = 1'b0;
    tick;
    i_range_wr = 1'b0;
    tick;
    chk("manual_wins_pulse", int'(o_range_changed), 1);
    chk("manual_wins_range", int'(o_range), 3);
    wait_idle();

    for (int it = 0; it < 300; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 8) begin
        manual_wr(2'($urandom_range(0, 3)), $urandom_range(0, 3));
      end else if (r < 12) begin
        set_auto(($urandom_range(0, 3) != 0));
      end else if (r < 15) begin
        flag_clear();
      end else begin
        int c = $urandom_range(0, 2);
        int len = $urandom_range(1, 6);
        for (int s = 0; s < len; s++) begin
          i_adc_state = 1'($urandom_range(0, 1));
          send_sample(rand_val(c), $urandom_range(0, 3), 1'b1);
          repeat ($urandom_range(0, 2)) tick;
        end
        chk("burst_over", int'(o_over_range), int'(mdl_over));
      end
      chk("iter_range", int'(o_range), int'(mdl_range));
    end

    // Reset in the middle of a settle returns straight to the reset state.
    begin
      logic [1:0] code = (mdl_range == 2'b01) ? 2'b10 : 2'b01;
      exp_q.push_back(code);
      i_manual_range = code;
      i_range_wr = 1'b1;
      i_adc_state = 1'b0;
      tick;
      i_range_wr = 1'b0;
      tick;
      repeat (3) tick;
      chk("mid_settle_busy", int'(o_range_busy), 1);
      i_fRST = 1'b0;
      #1;
      chk("arst_range", int'(o_range), 3);
      chk("arst_busy", int'(o_range_busy), 0);
      chk("arst_changed", int'(o_range_changed), 0);
      tick;
      i_fRST = 1'b1;
      mdl_range = 2'b11;
      mdl_over = 1'b0;
      hi_run = 0;
      lo_run = 0;
      repeat (15) tick;
      chk("arst_range_after", int'(o_range), 3);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
